// File: rtl/data_memory_responder_if.sv
// Data-memory bus between a processor-side initiator and the memory responder.
// The initiator raises memRead or memWrite, holds it until mem_ready, then drops it.
interface data_memory_responder_if;
  logic [17:0] address;
  logic [31:0] write_data;
  logic        memRead;
  logic        memWrite;
  logic [31:0] read_data;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_error;

  // Initiator side (datapath or testbench)
  modport master (
    output address, write_data, memRead, memWrite,
    input  read_data, mem_ready, mem_busy, mem_error
  );

  // Responder side (the memory)
  modport slave (
    input  address, write_data, memRead, memWrite,
    output read_data, mem_ready, mem_busy, mem_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed 32-bit data memory with a fixed access latency and a
// four-phase ready handshake. Illegal requests (both ops at once, or an
// address past the end) complete after one edge with mem_error set and
// never touch the array.
module data_memory_responder #(
  parameter int DEPTH   = 1024,  // number of 32-bit words, at most 2^18
  parameter int LATENCY = 2      // edges from acceptance to mem_ready, 1..15
) (
  input  logic                    clock,
  input  logic                    reset_n,
  data_memory_responder_if.slave  bus
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [18:0] DEPTH_L   = 19'(DEPTH);
  localparam logic [3:0]  CNT_START = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [IDX_W-1:0]   addr_q,      addr_d;
  logic [31:0]        wdata_q,     wdata_d;
  logic               op_write_q,  op_write_d;
  logic [3:0]         cnt_q,       cnt_d;
  logic [31:0]        read_data_q, read_data_d;
  logic               ready_q,     ready_d;
  logic               busy_q,      busy_d;
  logic               error_q,     error_d;

  // Storage array; never reset so it maps onto block RAM.
  logic [31:0]        mem_array [DEPTH];
  logic [31:0]        mem_rd_q;
  logic [IDX_W-1:0]   rd_idx;
  logic               mem_we;

  logic               req_one;
  logic               req_any;
  logic               addr_ok;

  // Request decode on the live bus inputs (only consulted in IDLE/DONE).
  always_comb begin
    req_one = bus.memRead ^ bus.memWrite;
    req_any = bus.memRead | bus.memWrite;
    addr_ok = ({1'b0, bus.address} < DEPTH_L);
  end

  // RAM read address: follow the bus while idle so the word for a read is
  // already in mem_rd_q one edge after acceptance; hold the latched address
  // afterwards so mid-transaction bus changes cannot disturb it.
  always_comb begin
    rd_idx = addr_q;
    if (state_q == IDLE) begin
      rd_idx = bus.address[IDX_W-1:0];
    end
  end

  // Synchronous RAM: write port from the latched request, registered read.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_array[addr_q] <= wdata_q;
    end
    mem_rd_q <= mem_array[rd_idx];
  end

  // State and output registers; reset drops any pending request immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_write_q  <= 1'b0;
      cnt_q       <= '0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_write_q  <= op_write_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY/DONE handshake.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_write_d  = op_write_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    error_d     = error_q;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_one && addr_ok) begin
          addr_d     = bus.address[IDX_W-1:0];
          wdata_d    = bus.write_data;
          op_write_d = bus.memWrite;
          cnt_d      = CNT_START;
          busy_d     = 1'b1;
          state_d    = BUSY;
        end else if (req_any) begin
          // Both ops or out-of-range address: complete with error, no access.
          ready_d    = 1'b1;
          error_d    = 1'b1;
          state_d    = DONE;
        end
      end

      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (op_write_q) begin
            mem_we = 1'b1;
          end else begin
            read_data_d = mem_rd_q;
          end
          busy_d  = 1'b0;
          ready_d = 1'b1;
          error_d = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        // Hold mem_ready until the initiator withdraws both requests.
        if (!bus.memRead && !bus.memWrite) begin
          ready_d = 1'b0;
          error_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        error_d = 1'b0;
      end
    endcase
  end

  // Every output comes straight from a register.
  always_comb begin
    bus.read_data = read_data_q;
    bus.mem_ready = ready_q;
    bus.mem_busy  = busy_q;
    bus.mem_error = error_q;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed table of transactions, hand-written
// reset sequences, then random traffic checked against an array model.
module tb_data_memory_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int NWORDS  = 16;    // random traffic stays inside this window

  logic clock;
  logic reset_n;

  data_memory_responder_if bus ();

  data_memory_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [17:0] addr;
    logic [31:0] data;
    int          hold;       // extra cycles to keep the request up after ready
    bit          exp_err;
    logic [31:0] exp_data;   // read_data expected once ready is seen
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t        vecs[$];
  logic [31:0] model_mem [NWORDS];
  logic [31:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit rd, input bit wr, input logic [17:0] a,
                              input logic [31:0] d, input int hold,
                              input bit err, input logic [31:0] exp_d);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.data = d; v.hold = hold;
    v.exp_err = err; v.exp_data = exp_d;
    return v;
  endfunction

  // Drive one full four-phase transaction starting just after a rising edge.
  task automatic run_txn(input vec_t v);
    int n;
    int exp_lat;
    exp_lat = v.exp_err ? 1 : LATENCY + 1;
    bus.address    = v.addr;
    bus.write_data = v.data;
    bus.memRead    = v.rd;
    bus.memWrite   = v.wr;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
      if (!bus.mem_ready && n < 40) begin
        check("busy_in_progress", {31'd0, bus.mem_busy}, 32'd1);
        // Disturb the bus mid-transaction; the latched request must win.
        bus.address    = 18'($urandom_range(0, NWORDS - 1));
        bus.write_data = $urandom;
      end
    end while (!bus.mem_ready && n < 40);
    check("latency", 32'(n), 32'(exp_lat));
    check("mem_error", {31'd0, bus.mem_error}, {31'd0, v.exp_err});
    check("busy_at_ready", {31'd0, bus.mem_busy}, 32'd0);
    check("read_data", bus.read_data, v.exp_data);
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clock); #1;
      check("ready_held", {31'd0, bus.mem_ready}, 32'd1);
      check("no_retrigger", {31'd0, bus.mem_busy}, 32'd0);
    end
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    @(posedge clock); #1;
    check("ready_drop", {31'd0, bus.mem_ready}, 32'd0);
    check("error_drop", {31'd0, bus.mem_error}, 32'd0);
    $display("txn rd=%0b wr=%0b addr=%0d wdata=%h -> lat=%0d err=%0b rdata=%h",
             v.rd, v.wr, v.addr, v.data, n, v.exp_err, v.exp_data);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bus.address = '0; bus.write_data = '0; bus.memRead = 1'b0; bus.memWrite = 1'b0;
    reset_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_read_data", bus.read_data, 32'd0);
    check("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
    check("rst_busy", {31'd0, bus.mem_busy}, 32'd0);
    check("rst_error", {31'd0, bus.mem_error}, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed table
    vecs.push_back(mk(0, 1, 18'd1,    32'h0000_07FF, 0, 0, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 18'd1,    32'h0,         0, 0, 32'h0000_07FF));
    vecs.push_back(mk(0, 1, 18'd5,    32'hA5A5_0005, 0, 0, 32'h0000_07FF));
    vecs.push_back(mk(1, 1, 18'd5,    32'hFFFF_FFFF, 0, 1, 32'h0000_07FF));
    vecs.push_back(mk(1, 0, 18'd5,    32'h0,         0, 0, 32'hA5A5_0005));
    vecs.push_back(mk(0, 1, 18'd0,    32'h1000_0000, 0, 0, 32'hA5A5_0005));
    vecs.push_back(mk(0, 1, 18'd1023, 32'h1000_03FF, 0, 0, 32'hA5A5_0005));
    vecs.push_back(mk(0, 1, 18'd1024, 32'hDEAD_BEEF, 0, 1, 32'hA5A5_0005));
    vecs.push_back(mk(1, 0, 18'd0,    32'h0,         0, 0, 32'h1000_0000));
    vecs.push_back(mk(1, 0, 18'd1023, 32'h0,         0, 0, 32'h1000_03FF));
    vecs.push_back(mk(1, 0, 18'd1,    32'h0,         3, 0, 32'h0000_07FF));
    vecs.push_back(mk(1, 0, 18'h3FFFF,32'h0,         0, 1, 32'h0000_07FF));
    vecs.push_back(mk(0, 1, 18'd7,    32'h1111_0007, 2, 0, 32'h0000_07FF));
    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset during DONE clears outputs without a clock edge
    bus.address = 18'd1; bus.memRead = 1'b1;
    for (int n = 0; n < 40 && !bus.mem_ready; n++) begin
      @(posedge clock); #1;
    end
    check("pre_reset_ready", {31'd0, bus.mem_ready}, 32'd1);
    check("pre_reset_data", bus.read_data, 32'h0000_07FF);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, bus.mem_ready}, 32'd0);
    check("async_rst_data", bus.read_data, 32'd0);
    check("async_rst_busy", {31'd0, bus.mem_busy}, 32'd0);
    check("async_rst_error", {31'd0, bus.mem_error}, 32'd0);
    bus.memRead = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    $display("txn reset during DONE");

    // Reset during BUSY cancels the pending write to addr 7
    bus.address = 18'd7; bus.write_data = 32'h1234_5678; bus.memWrite = 1'b1;
    @(posedge clock); #1;
    check("busy_before_reset", {31'd0, bus.mem_busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("busy_after_reset", {31'd0, bus.mem_busy}, 32'd0);
    bus.memWrite = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    $display("txn reset during BUSY write addr=7");
    run_txn(mk(1, 0, 18'd7, 32'h0, 0, 0, 32'h1111_0007));
    last_rd = 32'h1111_0007;

    // Random traffic against an array model: seed every word first
    for (int a = 0; a < NWORDS; a++) begin
      model_mem[a] = $urandom;
      run_txn(mk(0, 1, 18'(a), model_mem[a], 0, 0, last_rd));
    end
    for (int k = 0; k < 60; k++) begin
      int r;
      int a;
      r = $urandom_range(0, 9);
      a = $urandom_range(0, NWORDS - 1);
      if (r < 4) begin
        v = mk(0, 1, 18'(a), $urandom, $urandom_range(0, 2), 0, last_rd);
        model_mem[a] = v.data;
      end else if (r < 8) begin
        v = mk(1, 0, 18'(a), $urandom, $urandom_range(0, 2), 0, model_mem[a]);
        last_rd = model_mem[a];
      end else if (r == 8) begin
        v = mk(1, 1, 18'(a), $urandom, 0, 1, last_rd);
      end else begin
        v = mk($urandom_range(0, 1) == 1, 1'b0, 18'(DEPTH + $urandom_range(0, 5000)),
               $urandom, 0, 1, last_rd);
        v.wr = !v.rd;
      end
      run_txn(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
